// File: rtl/hazard_scoreboard.sv
// Pipeline hazard controller with a register scoreboard for variable-latency ops.
// Latency: control outputs are combinational. Scoreboard, counters and error flag update one cycle later.
// Backpressure: dmem_stall freezes MEM and the earlier stages. Data hazards hold IF/ID and insert an EX bubble.
module hazard_scoreboard #(
  parameter int NREGS       = 32,
  parameter int MAX_PENDING = 4,
  parameter int CNT_W       = 32
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [4:0]                         id_rs1,
  input  logic [4:0]                         id_rs2,
  input  logic [4:0]                         id_rd,
  input  logic                               id_valid,
  input  logic                               id_branch,
  input  logic                               id_is_long,
  input  logic [4:0]                         id_ex_rd,
  input  logic                               id_ex_mem_read,
  input  logic                               long_wb_valid,
  input  logic [4:0]                         long_wb_rd,
  input  logic                               dmem_stall,
  input  logic                               PCSrc,
  input  logic                               jump_id_stage,
  output logic                               stall_if,
  output logic                               stall_id,
  output logic                               stall_ex_mem,
  output logic                               flush_id,
  output logic                               flush_ex,
  output logic [NREGS-1:0]                   busy_vec,
  output logic [$clog2(MAX_PENDING+1)-1:0]   pending_cnt,
  output logic [CNT_W-1:0]                   stall_cycles,
  output logic                               sb_err
);

  localparam int PW = $clog2(MAX_PENDING + 1);

  logic [NREGS-1:0] wb_mask;
  logic [NREGS-1:0] eff_busy;
  logic             rs1_busy, rs2_busy, rd_busy;
  logic             ex_dep;
  logic             haz_lu, haz_br, haz_sb, haz_full, data_haz;
  logic             issue;
  logic [NREGS-1:0] busy_d;

  // Writeback mask: a register written back this cycle is already treated as free.
  always_comb begin
    wb_mask = '0;
    for (int i = 1; i < NREGS; i++) begin
      if (long_wb_valid && long_wb_rd == 5'(i)) wb_mask[i] = 1'b1;
    end
  end

  assign eff_busy = busy_vec & ~wb_mask;

  // Scoreboard lookups for the ID operands and destination. x0 is never busy.
  always_comb begin
    rs1_busy = 1'b0;
    rs2_busy = 1'b0;
    rd_busy  = 1'b0;
    for (int i = 1; i < NREGS; i++) begin
      if (id_rs1 == 5'(i)) rs1_busy = eff_busy[i];
      if (id_rs2 == 5'(i)) rs2_busy = eff_busy[i];
      if (id_rd  == 5'(i)) rd_busy  = eff_busy[i];
    end
  end

  assign ex_dep   = (id_ex_rd != 5'd0) && ((id_ex_rd == id_rs1) || (id_ex_rd == id_rs2));
  assign haz_lu   = id_ex_mem_read && ex_dep;
  assign haz_br   = !id_ex_mem_read && id_branch && ex_dep;
  assign haz_sb   = id_valid && (rs1_busy || rs2_busy || rd_busy);
  assign haz_full = id_valid && id_is_long && (pending_cnt == PW'(MAX_PENDING)) && !long_wb_valid;
  assign data_haz = haz_lu || haz_br || haz_sb || haz_full;
  assign issue    = id_valid && id_is_long && !dmem_stall && !PCSrc && !data_haz;

  // Prioritised pipeline control: memory freeze, then redirect, then data hazard, then jump.
  always_comb begin
    stall_if     = 1'b0;
    stall_id     = 1'b0;
    stall_ex_mem = 1'b0;
    flush_id     = 1'b0;
    flush_ex     = 1'b0;
    if (dmem_stall) begin
      stall_if     = 1'b1;
      stall_id     = 1'b1;
      stall_ex_mem = 1'b1;
    end else if (PCSrc) begin
      flush_id = 1'b1;
      flush_ex = 1'b1;
    end else if (data_haz) begin
      stall_if = 1'b1;
      stall_id = 1'b1;
      flush_ex = 1'b1;
    end else if (jump_id_stage) begin
      flush_id = 1'b1;
    end
  end

  // Next scoreboard value: writeback clears, issue sets, and a set wins on the same register.
  always_comb begin
    busy_d = busy_vec;
    if (long_wb_valid) begin
      for (int i = 0; i < NREGS; i++) begin
        if (long_wb_rd == 5'(i)) busy_d[i] = 1'b0;
      end
    end
    if (issue && id_rd != 5'd0) begin
      for (int i = 0; i < NREGS; i++) begin
        if (id_rd == 5'(i)) busy_d[i] = 1'b1;
      end
    end
    busy_d[0] = 1'b0;
  end

  // Registered state: scoreboard, in-flight count, sticky error and the stall counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_vec     <= '0;
      pending_cnt  <= '0;
      stall_cycles <= '0;
      sb_err       <= 1'b0;
    end else begin
      busy_vec <= busy_d;
      case ({issue, long_wb_valid})
        2'b10: pending_cnt <= pending_cnt + 1'b1;
        2'b01: begin
          if (pending_cnt != '0) pending_cnt <= pending_cnt - 1'b1;
          else                   sb_err      <= 1'b1;
        end
        default: pending_cnt <= pending_cnt;
      endcase
      if (!dmem_stall && !PCSrc && data_haz && stall_cycles != '1)
        stall_cycles <= stall_cycles + 1'b1;
    end
  end

endmodule
